// File: rtl/slfifo_stream_arbiter_pkg.sv
// slfifo_stream_arbiter_pkg: shared states, socket addresses and burst sizes for the SX3 stream arbiter
package slfifo_stream_arbiter_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT_RDY,
    ST_BURST,
    ST_DRAIN,
    ST_PKTEND,
    ST_GAP
  } state_e;
  localparam logic [15:0] BURST_WORDS    = 16'd1024;
  localparam logic [11:0] AUD_PKT_WORDS  = 12'd96;
  localparam int          ADDR_SETUP_CYC = 3;
  localparam logic [1:0]  VID_ADDR       = 2'b00;
  localparam logic [1:0]  AUD_ADDR       = 2'b11;
endpackage

// File: rtl/slfifo_stream_arbiter_pick.sv
// slfifo_arb_pick: stream eligibility and round-robin choice between video and audio
module slfifo_arb_pick
  import slfifo_stream_arbiter_pkg::*;
(
  input  logic        cam_app_en_i,
  input  logic        aud_app_en_i,
  input  logic        vid_fifo_empty_i,
  input  logic        vid_fifo_almost_empty_i,
  input  logic        frame_pend_i,
  input  logic [11:0] aud_fifo_rd_count_i,
  input  logic        last_aud_i,
  output logic        req_o,
  output logic        pick_aud_o,
  output logic        short_o
);
  logic aud_elig;
  logic vid_elig;
  // a full audio packet or a full video buffer (or the tail of a finished frame) makes a stream eligible
  always_comb begin
    aud_elig   = aud_app_en_i & (aud_fifo_rd_count_i >= AUD_PKT_WORDS);
    vid_elig   = cam_app_en_i & (~vid_fifo_almost_empty_i | (frame_pend_i & ~vid_fifo_empty_i));
    req_o      = aud_elig | vid_elig;
    pick_aud_o = aud_elig & (~vid_elig | ~last_aud_i);
    short_o    = frame_pend_i & vid_fifo_almost_empty_i;
  end
endmodule

// File: rtl/slfifo_stream_arbiter.sv
// slfifo_stream_arbiter: moves video bursts and audio packets from their FIFOs onto the SX3 slave-FIFO bus
module slfifo_stream_arbiter
  import slfifo_stream_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cam_app_en_i,
  input  logic        aud_app_en_i,
  input  logic        flaga_i,
  input  logic        flagb_i,
  input  logic        vid_fifo_empty_i,
  input  logic        vid_fifo_almost_empty_i,
  input  logic        vid_frame_end_i,
  input  logic [11:0] aud_fifo_rd_count_i,
  output logic        vid_rd_req_o,
  output logic        aud_rd_req_o,
  output logic        sel_aud_o,
  output logic [1:0]  sl_addr_o,
  output logic        slcs_o,
  output logic        slwr_o,
  output logic        pktend_o,
  output logic        busy_o
);
  state_e      state_q, state_d;
  logic        grant_aud_q, grant_aud_d;
  logic        short_q, short_d;
  logic        last_aud_q, last_aud_d;
  logic        frame_pend_q, frame_pend_d;
  logic        pkt_q, pkt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [2:0]  setup_cnt_q, setup_cnt_d;
  logic        slcs_q, slcs_d;
  logic        slwr_q, slwr_d;
  logic        pktend_q, pktend_d;
  logic        busy_q, busy_d;
  logic        sel_aud_q, sel_aud_d;
  logic [1:0]  sl_addr_q, sl_addr_d;
  logic        req, pick_aud, pick_short;
  logic        vid_rd, aud_rd, rd_any;
  logic [15:0] words;

  slfifo_arb_pick u_pick (
    .cam_app_en_i            (cam_app_en_i),
    .aud_app_en_i            (aud_app_en_i),
    .vid_fifo_empty_i        (vid_fifo_empty_i),
    .vid_fifo_almost_empty_i (vid_fifo_almost_empty_i),
    .frame_pend_i            (frame_pend_q),
    .aud_fifo_rd_count_i     (aud_fifo_rd_count_i),
    .last_aud_i              (last_aud_q),
    .req_o                   (req),
    .pick_aud_o              (pick_aud),
    .short_o                 (pick_short)
  );

  // read strobes come straight from the burst state so a short burst stops the moment the FIFO runs dry
  always_comb begin
    vid_rd = (state_q == ST_BURST) & ~grant_aud_q & (~short_q | ~vid_fifo_empty_i);
    aud_rd = (state_q == ST_BURST) & grant_aud_q;
    rd_any = vid_rd | aud_rd;
    words  = word_cnt_q + 16'(rd_any);
  end

  // next-state, counters and registered bus outputs
  always_comb begin
    state_d     = state_q;
    grant_aud_d = grant_aud_q;
    short_d     = short_q;
    last_aud_d  = last_aud_q;
    pkt_d       = pkt_q;
    word_cnt_d  = word_cnt_q;
    setup_cnt_d = setup_cnt_q;
    case (state_q)
      ST_IDLE: if (req) begin
        state_d     = ST_ADDR;
        grant_aud_d = pick_aud;
        short_d     = ~pick_aud & pick_short;
        word_cnt_d  = '0;
        setup_cnt_d = '0;
      end
      ST_ADDR: begin
        state_d     = (setup_cnt_q == 3'(ADDR_SETUP_CYC - 1)) ? ST_WAIT_RDY : ST_ADDR;
        setup_cnt_d = setup_cnt_q + 3'd1;
      end
      ST_WAIT_RDY: state_d = flaga_i ? ST_BURST : ST_WAIT_RDY;
      ST_BURST: begin
        word_cnt_d = words;
        if (grant_aud_q ? (words == {4'd0, AUD_PKT_WORDS}) : (words == BURST_WORDS)) begin
          state_d = ST_DRAIN;
          pkt_d   = grant_aud_q;
        end else if (~flagb_i | ~rd_any) begin
          state_d = ST_DRAIN;
          pkt_d   = 1'b1;
        end
      end
      ST_DRAIN:  state_d = pkt_q ? ST_PKTEND : ST_GAP;
      ST_PKTEND: state_d = ST_GAP;
      ST_GAP: begin
        state_d    = ST_IDLE;
        last_aud_d = grant_aud_q;
      end
      default: state_d = ST_IDLE;
    endcase
    slcs_d       = state_d inside {ST_IDLE, ST_GAP};
    pktend_d     = state_d != ST_PKTEND;
    busy_d       = state_d != ST_IDLE;
    slwr_d       = ~rd_any;
    sel_aud_d    = (state_q == ST_IDLE && req) ? pick_aud : sel_aud_q;
    sl_addr_d    = (state_q == ST_IDLE && req) ? (pick_aud ? AUD_ADDR : VID_ADDR) : sl_addr_q;
    frame_pend_d = vid_frame_end_i | (frame_pend_q & ~(state_q == ST_DRAIN && pkt_q && ~grant_aud_q));
  end

  // state and output registers; reset aborts any burst without a packet end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      grant_aud_q  <= 1'b0;
      short_q      <= 1'b0;
      last_aud_q   <= 1'b1;
      frame_pend_q <= 1'b0;
      pkt_q        <= 1'b0;
      word_cnt_q   <= '0;
      setup_cnt_q  <= '0;
      slcs_q       <= 1'b1;
      slwr_q       <= 1'b1;
      pktend_q     <= 1'b1;
      busy_q       <= 1'b0;
      sel_aud_q    <= 1'b0;
      sl_addr_q    <= VID_ADDR;
    end else begin
      state_q      <= state_d;
      grant_aud_q  <= grant_aud_d;
      short_q      <= short_d;
      last_aud_q   <= last_aud_d;
      frame_pend_q <= frame_pend_d;
      pkt_q        <= pkt_d;
      word_cnt_q   <= word_cnt_d;
      setup_cnt_q  <= setup_cnt_d;
      slcs_q       <= slcs_d;
      slwr_q       <= slwr_d;
      pktend_q     <= pktend_d;
      busy_q       <= busy_d;
      sel_aud_q    <= sel_aud_d;
      sl_addr_q    <= sl_addr_d;
    end
  end

  assign vid_rd_req_o = vid_rd;
  assign aud_rd_req_o = aud_rd;
  assign sel_aud_o    = sel_aud_q;
  assign sl_addr_o    = sl_addr_q;
  assign slcs_o       = slcs_q;
  assign slwr_o       = slwr_q;
  assign pktend_o     = pktend_q;
  assign busy_o       = busy_q;
endmodule

// File: tb/tb_slfifo_stream_arbiter.sv
// tb_slfifo_stream_arbiter: directed and randomized checks of burst sizes, packet ends, arbitration and reset
module tb_slfifo_stream_arbiter;
  import slfifo_stream_arbiter_pkg::*;

  typedef struct packed {
    logic       sel;
    logic [1:0] addr;
    int         rd;
    int         wr;
    int         pk;
  } rec_t;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        cam_app_en_i = 1'b0;
  logic        aud_app_en_i = 1'b0;
  logic        flaga_i = 1'b1;
  logic        flagb_i = 1'b1;
  logic        vid_fifo_empty_i;
  logic        vid_fifo_almost_empty_i;
  logic        vid_frame_end_i = 1'b0;
  logic [11:0] aud_fifo_rd_count_i;
  logic        vid_rd_req_o, aud_rd_req_o, sel_aud_o, slcs_o, slwr_o, pktend_o, busy_o;
  logic [1:0]  sl_addr_o;

  int vid_push = 0, vid_pop = 0, aud_push = 0, aud_pop = 0;
  int cur_rd = 0, cur_wr = 0, cur_pk = 0;
  int rd_total = 0, wr_total = 0, pk_total = 0;
  int lag_err = 0, pk_err = 0, stab_err = 0, rd_err = 0;
  logic       prev_rd = 1'b0, in_burst = 1'b0, cur_sel = 1'b0;
  logic [1:0] cur_addr = 2'b00;
  rec_t recs[$];
  int n_assert = 0, n_fail = 0;

  slfifo_stream_arbiter dut (
    .clk_i                   (clk_i),
    .rstn_i                  (rstn_i),
    .cam_app_en_i            (cam_app_en_i),
    .aud_app_en_i            (aud_app_en_i),
    .flaga_i                 (flaga_i),
    .flagb_i                 (flagb_i),
    .vid_fifo_empty_i        (vid_fifo_empty_i),
    .vid_fifo_almost_empty_i (vid_fifo_almost_empty_i),
    .vid_frame_end_i         (vid_frame_end_i),
    .aud_fifo_rd_count_i     (aud_fifo_rd_count_i),
    .vid_rd_req_o            (vid_rd_req_o),
    .aud_rd_req_o            (aud_rd_req_o),
    .sel_aud_o               (sel_aud_o),
    .sl_addr_o               (sl_addr_o),
    .slcs_o                  (slcs_o),
    .slwr_o                  (slwr_o),
    .pktend_o                (pktend_o),
    .busy_o                  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO occupancy model: words pushed by the stimulus, popped on each read strobe
  assign vid_fifo_empty_i        = (vid_push - vid_pop) == 0;
  assign vid_fifo_almost_empty_i = (vid_push - vid_pop) < 1024;
  assign aud_fifo_rd_count_i     = 12'(aud_push - aud_pop);
  always @(posedge clk_i) begin
    if (vid_rd_req_o) vid_pop <= vid_pop + 1;
    if (aud_rd_req_o) aud_pop <= aud_pop + 1;
  end

  // bus monitor: one record per chip-select window, plus protocol rule counters
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      cur_rd   <= 0;
      cur_wr   <= 0;
      cur_pk   <= 0;
      in_burst <= 1'b0;
      prev_rd  <= 1'b0;
    end else begin
      prev_rd  <= vid_rd_req_o | aud_rd_req_o;
      in_burst <= !slcs_o;
      if (vid_rd_req_o | aud_rd_req_o) begin
        cur_rd   <= cur_rd + 1;
        rd_total <= rd_total + 1;
      end
      if (!slwr_o) begin
        cur_wr   <= cur_wr + 1;
        wr_total <= wr_total + 1;
      end
      if (slwr_o === prev_rd) lag_err <= lag_err + 1;
      if ((vid_rd_req_o && vid_fifo_empty_i) || (vid_rd_req_o && aud_rd_req_o)) rd_err <= rd_err + 1;
      if (!pktend_o) begin
        cur_pk   <= cur_pk + 1;
        pk_total <= pk_total + 1;
        if (!slwr_o || vid_rd_req_o || aud_rd_req_o) pk_err <= pk_err + 1;
      end
      if (!slcs_o && !in_burst) begin
        cur_sel  <= sel_aud_o;
        cur_addr <= sl_addr_o;
      end
      if (!slcs_o && in_burst && (sel_aud_o !== cur_sel || sl_addr_o !== cur_addr)) stab_err <= stab_err + 1;
      if (slcs_o && in_burst) begin
        recs.push_back('{sel: cur_sel, addr: cur_addr, rd: cur_rd, wr: cur_wr, pk: cur_pk});
        cur_rd <= 0;
        cur_wr <= 0;
        cur_pk <= 0;
      end
    end
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // expected video burst length: full buffer unless the frame tail is shorter, cut short by flagb
  function automatic int model_vid_words(input int occ, input bit short_mode, input int cut);
    int n;
    n = (short_mode && occ < 1024) ? occ : 1024;
    return (cut > 0 && cut < n) ? cut : n;
  endfunction

  task automatic check_burst(input string tag, input bit exp_sel, input int exp_words, input bit exp_pk);
    rec_t r;
    for (int i = 0; i < 4000 && recs.size() == 0; i++) step();
    chk({tag, "_done"}, 32'(recs.size() != 0), 1);
    r = (recs.size() != 0) ? recs.pop_front() : '0;
    chk({tag, "_sel"}, r.sel, exp_sel);
    chk({tag, "_addr"}, r.addr, exp_sel ? AUD_ADDR : VID_ADDR);
    chk({tag, "_rd"}, r.rd, exp_words);
    chk({tag, "_wr"}, r.wr, exp_words);
    chk({tag, "_pktend"}, r.pk, exp_pk);
  endtask

  initial begin
    int occ, n, rs, ws, pks;
    bit last_aud, exp_aud;
    repeat (3) step();
    chk("rst_busy", busy_o, 0);
    chk("rst_slcs", slcs_o, 1);
    chk("rst_slwr", slwr_o, 1);
    chk("rst_pktend", pktend_o, 1);
    chk("rst_addr", sl_addr_o, VID_ADDR);
    chk("rst_sel", sel_aud_o, 0);
    chk("rst_rd", {vid_rd_req_o, aud_rd_req_o}, 0);
    rstn_i = 1'b1;
    repeat (2) step();

    cam_app_en_i = 1'b1;
    vid_push += 1024 + 37;
    occ = vid_push - vid_pop;
    check_burst("vid_full", 0, model_vid_words(occ, 0, 0), 0);

    vid_frame_end_i = 1'b1;
    step();
    vid_frame_end_i = 1'b0;
    occ = vid_push - vid_pop;
    check_burst("vid_short37", 0, model_vid_words(occ, 1, 0), 1);
    vid_push += 5;
    repeat (50) step();
    chk("frame_pend_cleared_idle", busy_o, 0);
    chk("frame_pend_cleared_norec", recs.size(), 0);

    n = $urandom_range(1, 900);
    vid_push += n;
    vid_frame_end_i = 1'b1;
    step();
    vid_frame_end_i = 1'b0;
    occ = vid_push - vid_pop;
    check_burst("vid_short_rand", 0, model_vid_words(occ, 1, 0), 1);

    flaga_i = 1'b0;
    vid_push += 1024;
    for (int i = 0; i < 50 && !busy_o; i++) step();
    chk("flaga_busy", busy_o, 1);
    rs = rd_total;
    ws = wr_total;
    repeat (50) step();
    chk("flaga_no_rd", rd_total, rs);
    chk("flaga_no_wr", wr_total, ws);
    chk("flaga_slcs", slcs_o, 0);
    flaga_i = 1'b1;
    check_burst("flaga_burst", 0, 1024, 0);

    vid_push += 1024;
    for (int i = 0; i < 2000 && cur_rd != 500; i++) step();
    step();
    flagb_i = 1'b0;
    n = model_vid_words(1024, 0, 501);
    check_burst("flagb", 0, n, n < 1024);
    flagb_i = 1'b1;

    vid_push += 501;
    for (int i = 0; i < 2000 && cur_rd != 200; i++) step();
    pks = pk_total;
    rstn_i = 1'b0;
    #1;
    chk("abort_busy", busy_o, 0);
    chk("abort_slcs", slcs_o, 1);
    chk("abort_slwr", slwr_o, 1);
    chk("abort_pktend", pktend_o, 1);
    chk("abort_rd", {vid_rd_req_o, aud_rd_req_o}, 0);
    chk("abort_addr", sl_addr_o, VID_ADDR);
    repeat (3) step();
    rstn_i = 1'b1;
    repeat (30) step();
    chk("abort_idle", busy_o, 0);
    chk("abort_no_pktend", pk_total, pks);
    chk("abort_norec", recs.size(), 0);

    cam_app_en_i = 1'b0;
    vid_push += 2100 + $urandom_range(0, 300);
    aud_push += 200 + $urandom_range(0, 100);
    step();
    cam_app_en_i = 1'b1;
    aud_app_en_i = 1'b1;
    last_aud = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_aud = !last_aud;
      last_aud = exp_aud;
      occ = vid_push - vid_pop;
      n = exp_aud ? int'(AUD_PKT_WORDS) : model_vid_words(occ, 0, 0);
      check_burst($sformatf("rr%0d", k), exp_aud, n, exp_aud || n < 1024);
    end
    cam_app_en_i = 1'b0;
    aud_app_en_i = 1'b0;
    repeat (10) step();

    chk("slwr_lag_rule", lag_err, 0);
    chk("pktend_rule", pk_err, 0);
    chk("addr_sel_stable", stab_err, 0);
    chk("read_rule", rd_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/slfifo_stream_arbiter.md
SLFIFO_STREAM_ARBITER -- requirements
Module: slfifo_stream_arbiter

Interface
REQ-001 BURST_WORDS, 16'd1024, words per full video burst (one SX3 DMA buffer).
REQ-002 AUD_PKT_WORDS, 12'd96, words per audio packet.
REQ-003 ADDR_SETUP_CYC, 3, cycles sl_addr_o is held before flaga_i is sampled.
REQ-004 VID_ADDR, 2'b00 / AUD_ADDR, 2'b11, SX3 socket addresses.
REQ-005 clk_i  in  1  single clock (pixel clock domain); rstn_i  in  1  asynchronous active-low reset.
REQ-006 cam_app_en_i  in  1  video streaming enabled.
REQ-007 aud_app_en_i  in  1  audio streaming enabled.
REQ-008 flaga_i  in  1  addressed socket ready (high = buffer free).
REQ-009 flagb_i  in  1  addressed socket watermark (low = buffer nearly full).
REQ-010 vid_fifo_empty_i / vid_fifo_almost_empty_i  in  1 each  video FIFO status; almost_empty low guarantees >= BURST_WORDS words.
REQ-011 vid_frame_end_i  in  1  single-cycle pulse, last pixel of frame written to video FIFO.
REQ-012 aud_fifo_rd_count_i  in  12  words in audio FIFO.
REQ-013 vid_rd_req_o / aud_rd_req_o  out  1 each  FIFO read strobes; data valid one cycle later.
REQ-014 sel_aud_o  out  1  external data mux select (1 = audio).
REQ-015 sl_addr_o  out  2;  slcs_o, slwr_o, pktend_o  out  1 each, active low.
REQ-016 busy_o  out  1  high in any state except IDLE.

Function
REQ-017 States: IDLE, ADDR, WAIT_RDY, BURST, DRAIN, PKTEND, GAP.
REQ-018 Eligibility: audio = aud_app_en_i & (aud_fifo_rd_count_i >= AUD_PKT_WORDS); video = cam_app_en_i & (~vid_fifo_almost_empty_i | (frame_pend & ~vid_fifo_empty_i)).
REQ-019 frame_pend set by vid_frame_end_i, cleared on entering PKTEND for video; simultaneous set and clear leaves it set.
REQ-020 IDLE: one eligible -> grant it; both eligible -> grant the requester not granted last (last_grant resets to audio, so video wins first tie); -> ADDR.
REQ-021 ADDR: sl_addr_o = granted socket, slcs_o low, counter runs ADDR_SETUP_CYC cycles -> WAIT_RDY.
REQ-022 WAIT_RDY: flaga_i high -> BURST; otherwise hold indefinitely.
REQ-023 BURST: rd_req high each cycle, word counter increments; slwr_o low exactly one cycle after each rd_req (delayed copy).
REQ-024 Video full burst: stop rd_req after BURST_WORDS words -> DRAIN; no pktend (buffer commits when full).
REQ-025 Video short burst (frame_pend, almost_empty): rd_req while ~vid_fifo_empty_i; empty -> DRAIN then PKTEND.
REQ-026 Audio: exactly AUD_PKT_WORDS words, then DRAIN -> PKTEND.
REQ-027 flagb_i low in BURST: rd_req drops next cycle, -> DRAIN -> PKTEND (short packet); remaining frame words re-arbitrate later.
REQ-028 DRAIN: one cycle, final slwr_o pulse issued; no rd_req.
REQ-029 PKTEND: pktend_o low one cycle with slwr_o high; -> GAP.
REQ-030 GAP: one cycle, slcs_o high, update last_grant -> IDLE.
REQ-031 Enable deassertion mid-burst does not truncate; the burst completes normally.
REQ-032 Word counter 16 bits, cleared on ADDR entry; never wraps (BURST_WORDS < 65536).
REQ-033 sel_aud_o stable from ADDR through GAP.

Reset
REQ-034 rstn_i low: state IDLE, all rd_req low, slcs_o/slwr_o/pktend_o high, sl_addr_o = VID_ADDR, sel_aud_o 0, busy_o 0, frame_pend 0, counters 0, last_grant audio.
REQ-035 Reset mid-burst aborts immediately; no pktend issued.

Structure
REQ-036 Shared package: state enumeration, VID_ADDR/AUD_ADDR, default BURST_WORDS/AUD_PKT_WORDS.
REQ-037 One sub-module natural: slfifo_arb_pick (combinational eligibility + round-robin pick); rest in one FSM.

Verification
REQ-038 Video only, almost_empty low, flaga_i high: 1024 rd_req, 1024 slwr_o pulses lagging 1 cycle, no pktend, sl_addr_o 00.
REQ-039 Frame end with 37 words left: short burst of 37 words, one pktend_o pulse after last slwr_o, frame_pend cleared.
REQ-040 Both eligible continuously: grants alternate video, audio, video; audio bursts 96 words each with pktend.
REQ-041 flaga_i low for 50 cycles after ADDR: no rd_req/slwr_o until flaga_i high; burst then completes.
REQ-042 flagb_i low at word 500 of video burst: rd_req stops next cycle, 501 writes total, pktend issued.
REQ-043 rstn_i asserted mid-burst at word 200: all outputs at reset values same cycle, no pktend; after release idle until eligible.
